// File: rtl/bias_apply_17_pkg.sv
// Shared layer-17 constants and types for the bias-apply stage.
package bias_apply_17_pkg;

    localparam int kern_s_k_17  = 4;
    localparam int coeff_width  = 16;
    localparam int acc_width_17 = 32;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Index width that stays legal when there is only one channel.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bias_apply_17_sat_add.sv
// Signed accumulator + bias add with clamp to the accumulator range; shared by the bias_apply_* layers.
import bias_apply_17_pkg::*;

module sat_add #(
    parameter int ACC_W   = acc_width_17,
    parameter int COEFF_W = coeff_width
) (
    input  logic [ACC_W-1:0]   acc,
    input  logic [COEFF_W-1:0] bias,
    output logic [ACC_W-1:0]   sum
);

    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W:0] sum_wide;
    logic           overflow;

    // One guard bit is enough: the two top bits disagree only on overflow.
    assign sum_wide = {acc[ACC_W-1], acc}
                    + {{(ACC_W+1-COEFF_W){bias[COEFF_W-1]}}, bias};
    assign overflow = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];

    always_comb begin
        sum = sum_wide[ACC_W-1:0];
        if (overflow) begin
            sum = sum_wide[ACC_W] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: rtl/bias_apply_17.sv
// Layer-17 bias apply: loads N_CH biases from one stream, then adds them channel-wise
// to the accumulator stream with saturation behind a one-entry output register.
import bias_apply_17_pkg::*;

module bias_apply_17 #(
    parameter int N_CH    = kern_s_k_17,
    parameter int COEFF_W = coeff_width,
    parameter int ACC_W   = acc_width_17
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    input  logic [COEFF_W-1:0] bias_V_dout,
    input  logic               bias_V_empty_n,
    output logic               bias_V_read,
    input  logic [ACC_W-1:0]   acc_V_dout,
    input  logic               acc_V_empty_n,
    output logic               acc_V_read,
    output logic [ACC_W-1:0]   output_V_din,
    input  logic               output_V_full_n,
    output logic               output_V_write,
    output logic               bias_loaded
);

    localparam int              IDX_W    = idx_width(N_CH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);

    state_e             state_reg;
    logic [IDX_W-1:0]   load_idx_reg;
    logic [IDX_W-1:0]   ch_reg;
    logic               out_valid_reg;
    logic [ACC_W-1:0]   out_data_reg;
    logic               bias_loaded_reg;
    logic [COEFF_W-1:0] bias_mem [N_CH];
    logic [N_CH-1:0]    bias_wr_en;
    logic [ACC_W-1:0]   sum_sat;

    logic bias_pop;
    logic acc_pop;
    logic out_push;

    assign bias_pop = (state_reg == ST_LOAD) && bias_V_empty_n;
    assign acc_pop  = (state_reg == ST_RUN) && acc_V_empty_n
                      && (!out_valid_reg || output_V_full_n);
    assign out_push = out_valid_reg && output_V_full_n;

    assign bias_V_read    = bias_pop;
    assign acc_V_read     = acc_pop;
    assign output_V_write = out_push;
    assign output_V_din   = out_data_reg;
    assign bias_loaded    = bias_loaded_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_wr_en
            assign bias_wr_en[gi] = bias_pop && (load_idx_reg == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                bias_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (bias_wr_en[i]) begin
                    bias_mem[i] <= bias_V_dout;
                end
            end
        end
    end

    // Bias for the current channel is read combinationally so the add lands in the pop cycle.
    sat_add #(
        .ACC_W   (ACC_W),
        .COEFF_W (COEFF_W)
    ) u_sat_add (
        .acc  (acc_V_dout),
        .bias (bias_mem[ch_reg]),
        .sum  (sum_sat)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_reg       <= ST_LOAD;
            load_idx_reg    <= '0;
            ch_reg          <= '0;
            out_valid_reg   <= 1'b0;
            out_data_reg    <= '0;
            bias_loaded_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_LOAD: begin
                    if (bias_pop) begin
                        if (load_idx_reg == LAST_IDX) begin
                            load_idx_reg    <= '0;
                            state_reg       <= ST_RUN;
                            bias_loaded_reg <= 1'b1;
                        end else begin
                            load_idx_reg <= load_idx_reg + IDX_W'(1);
                        end
                    end
                end
                ST_RUN: begin
                    // A pop overwrites the register even when it is pushed in the same cycle.
                    if (acc_pop) begin
                        out_data_reg  <= sum_sat;
                        out_valid_reg <= 1'b1;
                        ch_reg        <= (ch_reg == LAST_IDX) ? '0 : ch_reg + IDX_W'(1);
                    end else if (out_push) begin
                        out_valid_reg <= 1'b0;
                    end
                end
                default: state_reg <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_bias_apply_17.sv
// Randomised and directed bench for bias_apply_17 against a queue-based stream model.
module tb_bias_apply_17;

    localparam int N_CH    = 4;
    localparam int COEFF_W = 16;
    localparam int ACC_W   = 32;

    logic               ap_clk = 1'b0;
    logic               ap_rst_n;
    logic [COEFF_W-1:0] bias_V_dout;
    logic               bias_V_empty_n;
    logic               bias_V_read;
    logic [ACC_W-1:0]   acc_V_dout;
    logic               acc_V_empty_n;
    logic               acc_V_read;
    logic [ACC_W-1:0]   output_V_din;
    logic               output_V_full_n;
    logic               output_V_write;
    logic               bias_loaded;

    int checks = 0;
    int errors = 0;

    // Model state: what the upstream FIFOs hold, what has been loaded, what is in flight.
    logic signed [COEFF_W-1:0] bias_src [$];
    logic signed [ACC_W-1:0]   acc_src  [$];
    logic signed [COEFF_W-1:0] bias_model [N_CH];
    logic [ACC_W-1:0]          exp_q   [$];
    logic [ACC_W-1:0]          out_log [$];
    int bias_cnt;
    int acc_cnt;

    bias_apply_17 #(
        .N_CH    (N_CH),
        .COEFF_W (COEFF_W),
        .ACC_W   (ACC_W)
    ) dut (
        .ap_clk          (ap_clk),
        .ap_rst_n        (ap_rst_n),
        .bias_V_dout     (bias_V_dout),
        .bias_V_empty_n  (bias_V_empty_n),
        .bias_V_read     (bias_V_read),
        .acc_V_dout      (acc_V_dout),
        .acc_V_empty_n   (acc_V_empty_n),
        .acc_V_read      (acc_V_read),
        .output_V_din    (output_V_din),
        .output_V_full_n (output_V_full_n),
        .output_V_write  (output_V_write),
        .bias_loaded     (bias_loaded)
    );

    always #5 ap_clk = ~ap_clk;

    function automatic logic [ACC_W-1:0] ref_sat(input longint a, input longint b);
        longint s;
        s = a + b;
        if (s > 64'sd2147483647)  return 32'h7fff_ffff;
        if (s < -64'sd2147483648) return 32'h8000_0000;
        return s[ACC_W-1:0];
    endfunction

    task automatic chk(input string tag, input logic [ACC_W-1:0] obs, input logic [ACC_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic refresh_data();
        if (bias_src.size() == 0) bias_src.push_back(COEFF_W'($urandom));
        if (acc_src.size() == 0)  acc_src.push_back(ACC_W'($urandom));
        bias_V_dout = bias_src[0];
        acc_V_dout  = acc_src[0];
    endtask

    task automatic drive(input logic be, input logic ae, input logic fn);
        bias_V_empty_n  = be;
        acc_V_empty_n   = ae;
        output_V_full_n = fn;
        refresh_data();
    endtask

    // One clock: check outputs at the falling edge, advance the model, step past the rising edge.
    task automatic tick();
        logic bpop, apop, opush;
        logic [ACC_W-1:0] dummy;
        @(negedge ap_clk);
        bpop  = (bias_cnt < N_CH) && bias_V_empty_n;
        apop  = (bias_cnt == N_CH) && acc_V_empty_n && (exp_q.size() == 0 || output_V_full_n);
        opush = (exp_q.size() > 0) && output_V_full_n;
        chk("bias_read",   {31'd0, bias_V_read},    {31'd0, bpop});
        chk("bias_loaded", {31'd0, bias_loaded},    {31'd0, (bias_cnt == N_CH)});
        chk("acc_read",    {31'd0, acc_V_read},     {31'd0, apop});
        chk("out_write",   {31'd0, output_V_write}, {31'd0, opush});
        if (exp_q.size() > 0) chk("out_din", output_V_din, exp_q[0]);
        if (output_V_write === 1'b1) out_log.push_back(output_V_din);
        if (opush) dummy = exp_q.pop_front();
        if (apop) begin
            exp_q.push_back(ref_sat(longint'(acc_src[0]), longint'(bias_model[acc_cnt % N_CH])));
            void'(acc_src.pop_front());
            acc_cnt++;
        end
        if (bpop) begin
            bias_model[bias_cnt] = bias_src.pop_front();
            bias_cnt++;
        end
        @(posedge ap_clk);
        #1;
        refresh_data();
    endtask

    task automatic do_reset();
        ap_rst_n = 1'b0;
        bias_cnt = 0;
        acc_cnt  = 0;
        exp_q.delete();
        bias_src.delete();
        acc_src.delete();
        out_log.delete();
        drive(1'b0, 1'b0, 1'b1);
        #1;
        chk("rst_bias_loaded", {31'd0, bias_loaded},    32'd0);
        chk("rst_out_write",   {31'd0, output_V_write}, 32'd0);
        chk("rst_acc_read",    {31'd0, acc_V_read},     32'd0);
        chk("rst_bias_read",   {31'd0, bias_V_read},    32'd0);
        chk("rst_out_din",     output_V_din,            32'd0);
        @(posedge ap_clk);
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
    endtask

    initial begin
        int guard;
        ap_rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b1);
        @(posedge ap_clk);
        #1;
        do_reset();

        // Load and apply, with three surplus bias words left upstream.
        bias_src = '{16'sd1, -16'sd2, 16'sd3, -16'sd4, 16'sd100, 16'sd200, 16'sd300};
        acc_src  = '{32'sd10, 32'sd10, 32'sd10, 32'sd10, 32'sd20};
        drive(1'b1, 1'b1, 1'b1);
        repeat (9) tick();
        drive(1'b1, 1'b0, 1'b1);
        repeat (3) tick();
        chk("load_apply_count", out_log.size(), 32'd5);
        if (out_log.size() == 5) begin
            chk("load_apply_0", out_log[0], 32'd11);
            chk("load_apply_1", out_log[1], 32'd8);
            chk("load_apply_2", out_log[2], 32'd13);
            chk("load_apply_3", out_log[3], 32'd6);
            chk("load_apply_4", out_log[4], 32'd21);
        end

        // Backpressure mid-stream.
        drive(1'b1, 1'b1, 1'b1);
        repeat (3) tick();
        drive(1'b1, 1'b1, 1'b0);
        repeat (5) tick();
        drive(1'b1, 1'b1, 1'b1);
        repeat (5) tick();
        drive(1'b1, 1'b0, 1'b1);
        repeat (3) tick();
        chk("bp_drained", exp_q.size(), 32'd0);

        // Random bubbles on every handshake, including during load.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) != 0));
            tick();
        end

        // Reset after two of four outputs, then reload with a flat bias.
        do_reset();
        bias_src = '{16'sd7, 16'sd7, 16'sd7, 16'sd7};
        acc_src  = '{32'sd1, 32'sd2, 32'sd3, 32'sd4};
        drive(1'b1, 1'b1, 1'b1);
        guard = 0;
        while (out_log.size() < 2 && guard < 20) begin
            tick();
            guard++;
        end
        chk("mid_run_two_out", out_log.size(), 32'd2);
        do_reset();
        bias_src = '{16'sd5, 16'sd5, 16'sd5, 16'sd5};
        acc_src  = '{32'sd0};
        drive(1'b1, 1'b1, 1'b1);
        repeat (5) tick();
        drive(1'b1, 1'b0, 1'b1);
        repeat (2) tick();
        chk("reload_count", out_log.size(), 32'd1);
        if (out_log.size() == 1) chk("reload_ch0", out_log[0], 32'd5);

        // Saturation at both ends of the accumulator range.
        do_reset();
        bias_src = '{16'sh7fff, -16'sd1, 16'sd0, 16'sd0};
        acc_src  = '{32'sh7fff_ffff, 32'sh8000_0000};
        drive(1'b1, 1'b1, 1'b1);
        repeat (6) tick();
        drive(1'b0, 1'b0, 1'b1);
        repeat (2) tick();
        chk("sat_count", out_log.size(), 32'd2);
        if (out_log.size() == 2) begin
            chk("sat_pos", out_log[0], 32'h7fff_ffff);
            chk("sat_neg", out_log[1], 32'h8000_0000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
